ball_motion_ctrl: RTL and testbench
===================================

# ball_motion_ctrl

Frame-rate ball motion engine for the bouncing-ball demos. It holds the ball's absolute X/Y position and velocity, and advances the position once per video frame on the rising edge of vsync. It clamps and reflects at the playfield borders and manages a serve countdown and pause. It sits directly upstream of the ball renderer: the renderer consumes `ball_hpos`/`ball_vpos` and compares them with the beam position. This block never uses vsync as a clock; everything runs on `clk`.

## Interface
- `BALL_SIZE`, 4: ball edge length in pixels.
- `H_LIMIT`, 256: playfield width; max X = `H_LIMIT-BALL_SIZE`.
- `V_LIMIT`, 240: playfield height; max Y = `V_LIMIT-BALL_SIZE`.
- `INIT_H`, 128: serve X position.
- `INIT_V`, 128: serve Y position.
- `SPEED`, 2: velocity magnitude in pixels/frame, per axis (1..15).
- `SERVE_DELAY`, 60: frames held at serve position before motion (1..255).

- `clk`  in  1  pixel clock, same clock as the sync generator.
- `reset`  in  1  synchronous, active-high.
- `vsync`  in  1  vertical sync from the sync generator; synchronous to `clk`.
- `serve`  in  1  one-cycle request to re-serve.
- `pause`  in  1  level; freezes motion, sampled at frame ticks.
- `ball_hpos`  out  9  ball left edge X.
- `ball_vpos`  out  9  ball top edge Y.
- `ball_hmove`  out  9  signed X velocity.
- `ball_vmove`  out  9  signed Y velocity.
- `hbounce`  out  1  one-cycle pulse on a horizontal reflection.
- `vbounce`  out  1  one-cycle pulse on a vertical reflection.
- `moving`  out  1  high while in MOVE.

## Operation
- Frame tick: `tick = vsync & ~vsync_q`, where `vsync_q` is a registered copy of `vsync`. `vsync_q` resets to 1, so a vsync already high at reset release gives no tick.
- States: SERVE, MOVE, PAUSED.
- Reset (all registered outputs):
  - state = SERVE, countdown = `SERVE_DELAY`.
  - position = (`INIT_H`, `INIT_V`).
  - `ball_hmove` = -`SPEED`, `ball_vmove` = +`SPEED`.
  - `hbounce` = `vbounce` = `moving` = 0.
- SERVE: each tick decrements countdown. The tick that takes countdown 1 -> 0 moves to MOVE. No position change occurs on that tick.
- MOVE, on a tick:
  - If `pause` = 1: go to PAUSED with no position update.
  - Otherwise update each axis independently:
    - Compute `next = pos + move` in 10-bit signed arithmetic (sign-extend both operands).
    - If `move` < 0 and `next` <= 0: pos = 0, move = -move, pulse the axis bounce.
    - If `move` > 0 and `next` >= LIMIT-BALL_SIZE: pos = LIMIT-BALL_SIZE, move = -move, pulse the axis bounce.
    - Otherwise pos = `next[8:0]`.
- PAUSED: a tick with `pause` = 0 returns to MOVE. No update happens on that tick.
- `serve` (any cycle, any state):
  - position = INIT, countdown reloads, state = SERVE.
  - Velocity signs are kept.
  - Pending bounce pulses are suppressed.
- Priority: `reset` > `serve` > tick. A `serve` coincident with a tick discards the tick.
- Both axes may bounce on the same tick; `hbounce` and `vbounce` then pulse together.
- Position never leaves [0, LIMIT-BALL_SIZE]; there is no 9-bit wrap-around.
- `pause` between ticks has no effect.

## Timing
- A tick is detected in cycle N (`vsync`=1, `vsync_q`=0). Position, velocity, state and bounce pulses update at the clock edge ending cycle N and are visible in cycle N+1.
- `hbounce`/`vbounce` are high for exactly cycle N+1.
- `moving` is registered and reflects the state from cycle N+1 onward.
- `serve` asserted in cycle M takes effect in cycle M+1.
- Outputs are stable between ticks, so the renderer sees constant coordinates for the whole frame.
- At most one position update per vsync pulse, regardless of pulse width.

## Test plan
- Reset, then 60 vsync pulses:
  - `moving` = 0 and position = (128,128) throughout.
  - `moving` = 1 after the 60th tick.
  - The 1st MOVE tick gives (126,130).
- Vertical bounce: the 54th MOVE tick gives `ball_vpos` = 236, `ball_vmove` = -2 and one `vbounce` pulse. The 55th gives 234.
- Horizontal bounce: the 64th MOVE tick gives `ball_hpos` = 0, `ball_hmove` = +2 and one `hbounce` pulse. The 65th gives 2.
- Clamp with `SPEED` = 3:
  - Left: `hpos` 2 moving -3 clamps to 0 and reflects to +3.
  - Right: `vpos` 235 moving +3 clamps to 236.
  - `next` in 10 bits never wraps.
- Pause: `pause` = 1 across 5 ticks holds position. Releasing it, the next tick leaves position unchanged (re-entry). The following tick moves by one step.
- `serve` pulse coincident with a tick in MOVE at (40,200):
  - Next cycle: (128,128), SERVE, `moving` = 0, no bounce.
  - A held-high vsync across reset produces no tick.

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// Frame-rate ball position/velocity engine: advances once per vsync rising edge,
// clamps and reflects at the playfield borders, and handles serve countdown and pause.
module ball_motion_ctrl #(
    parameter int BALL_SIZE   = 4,
    parameter int H_LIMIT     = 256,
    parameter int V_LIMIT     = 240,
    parameter int INIT_H      = 128,
    parameter int INIT_V      = 128,
    parameter int SPEED       = 2,
    parameter int SERVE_DELAY = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       serve,
    input  logic       pause,
    output logic [8:0] ball_hpos,
    output logic [8:0] ball_vpos,
    output logic [8:0] ball_hmove,
    output logic [8:0] ball_vmove,
    output logic       hbounce,
    output logic       vbounce,
    output logic       moving
);

    typedef enum logic [1:0] {
        ST_SERVE,
        ST_MOVE,
        ST_PAUSED
    } state_t;

    localparam logic signed [9:0] H_MAX   = 10'(H_LIMIT - BALL_SIZE);
    localparam logic signed [9:0] V_MAX   = 10'(V_LIMIT - BALL_SIZE);
    localparam logic [8:0]        SPD     = 9'(SPEED);
    localparam logic [8:0]        NEG_SPD = ~SPD + 9'd1;
    localparam logic [8:0]        POS_H0  = 9'(INIT_H);
    localparam logic [8:0]        POS_V0  = 9'(INIT_V);
    localparam logic [7:0]        DELAY   = 8'(SERVE_DELAY);

    state_t     state_q;
    logic       vsync_q;
    logic [7:0] count_q;
    logic [8:0] hpos_q, vpos_q, hmove_q, vmove_q;
    logic       hbounce_q, vbounce_q, moving_q;

    logic        tick;
    logic [18:0] h_step_d, v_step_d;

    // One axis step: returns {bounce, new_move, new_pos}. The 10-bit sum keeps
    // overshoot past either border visible so the clamp never sees a wrapped value.
    function automatic logic [18:0] axis_step(input logic [8:0] pos,
                                              input logic [8:0] move,
                                              input logic signed [9:0] lim);
        logic signed [9:0] sum;
        logic [8:0]        neg;
        sum = $signed({pos[8], pos}) + $signed({move[8], move});
        neg = ~move + 9'd1;
        if (move[8] && (sum <= 10'sd0)) begin
            axis_step = {1'b1, neg, 9'd0};
        end else if (!move[8] && (move != 9'd0) && (sum >= lim)) begin
            axis_step = {1'b1, neg, lim[8:0]};
        end else begin
            axis_step = {1'b0, move, sum[8:0]};
        end
    endfunction

    assign tick     = vsync & ~vsync_q;
    assign h_step_d = axis_step(hpos_q, hmove_q, H_MAX);
    assign v_step_d = axis_step(vpos_q, vmove_q, V_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SERVE;
            vsync_q   <= 1'b1;
            count_q   <= DELAY;
            hpos_q    <= POS_H0;
            vpos_q    <= POS_V0;
            hmove_q   <= NEG_SPD;
            vmove_q   <= SPD;
            hbounce_q <= 1'b0;
            vbounce_q <= 1'b0;
            moving_q  <= 1'b0;
        end else begin
            vsync_q   <= vsync;
            hbounce_q <= 1'b0;
            vbounce_q <= 1'b0;
            if (serve) begin
                // Velocity signs survive a re-serve; only position and countdown restart.
                state_q  <= ST_SERVE;
                count_q  <= DELAY;
                hpos_q   <= POS_H0;
                vpos_q   <= POS_V0;
                moving_q <= 1'b0;
            end else if (tick) begin
                case (state_q)
                    ST_SERVE: begin
                        count_q <= count_q - 8'd1;
                        if (count_q == 8'd1) begin
                            state_q  <= ST_MOVE;
                            moving_q <= 1'b1;
                        end
                    end
                    ST_MOVE: begin
                        if (pause) begin
                            state_q  <= ST_PAUSED;
                            moving_q <= 1'b0;
                        end else begin
                            hpos_q    <= h_step_d[8:0];
                            hmove_q   <= h_step_d[17:9];
                            hbounce_q <= h_step_d[18];
                            vpos_q    <= v_step_d[8:0];
                            vmove_q   <= v_step_d[17:9];
                            vbounce_q <= v_step_d[18];
                        end
                    end
                    ST_PAUSED: begin
                        if (!pause) begin
                            state_q  <= ST_MOVE;
                            moving_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= ST_SERVE;
                        moving_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ball_hpos  = hpos_q;
    assign ball_vpos  = vpos_q;
    assign ball_hmove = hmove_q;
    assign ball_vmove = vmove_q;
    assign hbounce    = hbounce_q;
    assign vbounce    = vbounce_q;
    assign moving     = moving_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: stimulus queues hand-computed frame results,
// a monitor pops and compares them the cycle after each frame tick or probe.
module tb_ball_motion_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, vsync, serve, pause, probe;
    bit   sel;

    logic [8:0] h0, v0, hm0, vm0, h3, v3, hm3, vm3;
    logic       hb0, vb0, mv0, hb3, vb3, mv3;

    ball_motion_ctrl dut (
        .clk(clk), .reset(reset), .vsync(vsync), .serve(serve), .pause(pause),
        .ball_hpos(h0), .ball_vpos(v0), .ball_hmove(hm0), .ball_vmove(vm0),
        .hbounce(hb0), .vbounce(vb0), .moving(mv0)
    );

    // Second instance exercises clamping with overshoot (speed 3, odd start row).
    ball_motion_ctrl #(.SPEED(3), .INIT_V(127), .SERVE_DELAY(2)) dut3 (
        .clk(clk), .reset(reset), .vsync(vsync), .serve(serve), .pause(pause),
        .ball_hpos(h3), .ball_vpos(v3), .ball_hmove(hm3), .ball_vmove(vm3),
        .hbounce(hb3), .vbounce(vb3), .moving(mv3)
    );

    logic [8:0] m_h, m_v, m_hm, m_vm;
    logic       m_hb, m_vb, m_mv;
    assign m_h  = sel ? h3  : h0;
    assign m_v  = sel ? v3  : v0;
    assign m_hm = sel ? hm3 : hm0;
    assign m_vm = sel ? vm3 : vm0;
    assign m_hb = sel ? hb3 : hb0;
    assign m_vb = sel ? vb3 : vb0;
    assign m_mv = sel ? mv3 : mv0;

    typedef struct {
        string      name;
        bit         chk;
        logic [8:0] h, v, hm, vm;
        logic       hb, vb, mv;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic exp_t mk(string n, int h, int v, int hm, int vm, bit hb, bit vb, bit mv);
        exp_t r;
        r.name = n; r.chk = 1'b1;
        r.h = 9'(h); r.v = 9'(v); r.hm = 9'(hm); r.vm = 9'(vm);
        r.hb = hb; r.vb = vb; r.mv = mv;
        return r;
    endfunction

    function automatic exp_t dc();
        exp_t r;
        r = mk("", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        r.chk = 1'b0;
        return r;
    endfunction

    // Monitor: its own edge detector marks the cycle in which the DUT sees a tick.
    logic  vs_tb_q;
    bit    pending = 1'b0;
    bit    chk_low = 1'b0;
    string low_name;
    exp_t  e;

    always @(posedge clk) vs_tb_q <= reset ? 1'b1 : vsync;

    always @(negedge clk) begin
        if (chk_low) begin
            tests++;
            if (m_hb || m_vb) begin
                fails++;
                $display("FAIL %s_pulse_width: hb=%0b vb=%0b one cycle later, expected 0 0",
                         low_name, m_hb, m_vb);
            end
            chk_low = 1'b0;
        end
        if (pending) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_underflow: update seen with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    tests++;
                    if (m_h !== e.h || m_v !== e.v || m_hm !== e.hm || m_vm !== e.vm ||
                        m_hb !== e.hb || m_vb !== e.vb || m_mv !== e.mv) begin
                        fails++;
                        $display("FAIL %s: got (%0d,%0d) mv=(%0d,%0d) hb=%0b vb=%0b moving=%0b, expected (%0d,%0d) mv=(%0d,%0d) hb=%0b vb=%0b moving=%0b",
                                 e.name, m_h, m_v, $signed(m_hm), $signed(m_vm), m_hb, m_vb, m_mv,
                                 e.h, e.v, $signed(e.hm), $signed(e.vm), e.hb, e.vb, e.mv);
                    end else begin
                        $display("[TB] ok %s (%0d,%0d)", e.name, m_h, m_v);
                    end
                    chk_low  = e.hb | e.vb;
                    low_name = e.name;
                end
            end
        end
        pending = ((vsync && !vs_tb_q) || probe) && !reset;
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int width, input bit srv, input exp_t x);
        exp_q.push_back(x);
        vsync = 1'b1;
        serve = srv;
        cycles(1);
        serve = 1'b0;
        cycles(width - 1);
        vsync = 1'b0;
        cycles(4);
    endtask

    task automatic do_probe(input exp_t x);
        exp_q.push_back(x);
        probe = 1'b1;
        cycles(1);
        probe = 1'b0;
        cycles(2);
    endtask

    exp_t x;

    initial begin
        reset = 1'b1; vsync = 1'b1; serve = 1'b0; pause = 1'b0; probe = 1'b0; sel = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(3);
        do_probe(mk("reset_state", 128, 128, -2, 2, 0, 0, 0));
        vsync = 1'b0;
        cycles(3);

        // Serve countdown: a spurious tick at reset release would start motion one frame early.
        for (int k = 1; k <= 60; k++)
            frame(2, 1'b0, mk($sformatf("serve_tick%0d", k), 128, 128, -2, 2, 0, 0, k == 60));

        for (int k = 1; k <= 65; k++) begin
            case (k)
                1:       x = mk("move1",  126, 130, -2,  2, 0, 0, 1);
                53:      x = mk("move53",  22, 234, -2,  2, 0, 0, 1);
                54:      x = mk("vbounce", 20, 236, -2, -2, 0, 1, 1);
                55:      x = mk("move55",  18, 234, -2, -2, 0, 0, 1);
                63:      x = mk("move63",   2, 218, -2, -2, 0, 0, 1);
                64:      x = mk("hbounce",  0, 216,  2, -2, 1, 0, 1);
                65:      x = mk("move65",   2, 214,  2, -2, 0, 0, 1);
                default: x = dc();
            endcase
            frame(1 + (k % 4), 1'b0, x);
        end

        pause = 1'b1;
        for (int k = 1; k <= 5; k++)
            frame(2, 1'b0, mk($sformatf("paused%0d", k), 2, 214, 2, -2, 0, 0, 0));
        pause = 1'b0;
        frame(2, 1'b0, mk("pause_reentry", 2, 214, 2, -2, 0, 0, 1));
        frame(2, 1'b0, mk("after_pause",   4, 212, 2, -2, 0, 0, 1));

        frame(2, 1'b1, mk("serve_on_tick", 128, 128, 2, -2, 0, 0, 0));
        frame(2, 1'b0, mk("reserve_hold",  128, 128, 2, -2, 0, 0, 0));

        sel   = 1'b1;
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(2);
        do_probe(mk("reset3_state", 128, 127, -3, 3, 0, 0, 0));
        frame(2, 1'b0, mk("s3_tick1", 128, 127, -3, 3, 0, 0, 0));
        frame(2, 1'b0, mk("s3_tick2", 128, 127, -3, 3, 0, 0, 1));
        for (int k = 1; k <= 44; k++) begin
            case (k)
                1:       x = mk("s3_move1",     125, 130, -3,  3, 0, 0, 1);
                36:      x = mk("s3_move36",     20, 235, -3,  3, 0, 0, 1);
                37:      x = mk("s3_clamp_bot",  17, 236, -3, -3, 0, 1, 1);
                42:      x = mk("s3_move42",      2, 221, -3, -3, 0, 0, 1);
                43:      x = mk("s3_clamp_left",  0, 218,  3, -3, 1, 0, 1);
                44:      x = mk("s3_move44",      3, 215,  3, -3, 0, 0, 1);
                default: x = dc();
            endcase
            frame(2, 1'b0, x);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycles(1);
        cycles(3);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
